// File: rtl/dec_counter.sv
// rtl/dec_counter.sv - loadable down-counter with IDLE/COUNT/DONE handshake
module dec_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] a_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             ack_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] out_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (load_i) begin
                    out_d   = a_i;
                    state_d = (a_i == '0) ? DONE : COUNT;
                end
            end
            COUNT: begin
                // Leaving at 1 -> 0 is what keeps the count from ever wrapping.
                if (en_i) begin
                    out_d = out_q - ONE;
                    if (out_q == ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                out_d = '0;
                if (ack_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = '0;
            end
        endcase
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q == COUNT);
    assign done_o  = (state_q == DONE);
    assign out_o   = out_q;

endmodule

// File: tb/tb_dec_counter.sv
// tb/tb_dec_counter.sv - directed self-checking bench for dec_counter
module tb_dec_counter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [15:0] a_i;
    logic        load_i;
    logic        en_i;
    logic        ack_i;
    logic        ready_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] out_o;

    int n_checks = 0;
    int n_fail   = 0;

    dec_counter #(.WIDTH(16)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .a_i    (a_i),
        .load_i (load_i),
        .en_i   (en_i),
        .ack_i  (ack_i),
        .ready_o(ready_o),
        .busy_o (busy_o),
        .done_o (done_o),
        .out_o  (out_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_out,
                           input logic e_rdy, input logic e_bsy, input logic e_dn);
        chk({tag, ".out"},   {16'h0, out_o},   {16'h0, e_out});
        chk({tag, ".ready"}, {31'h0, ready_o}, {31'h0, e_rdy});
        chk({tag, ".busy"},  {31'h0, busy_o},  {31'h0, e_bsy});
        chk({tag, ".done"},  {31'h0, done_o},  {31'h0, e_dn});
    endtask

    initial begin
        logic [7:0]  en_pat;
        logic [15:0] exp_seq [9];
        rst_ni = 1'b0;
        a_i    = 16'h0;
        load_i = 1'b0;
        en_i   = 1'b0;
        ack_i  = 1'b0;
        #3;
        chk_all("reset", 16'h0, 1, 0, 0);
        step();
        rst_ni = 1'b1;

        // Count 0xAB with constant enable
        load_i = 1; a_i = 16'h00AB; en_i = 1;
        step();
        load_i = 0; a_i = 16'h5555;
        chk_all("ab_load", 16'h00AB, 0, 1, 0);
        for (int i = 1; i <= 171; i++) begin
            step();
            chk_all("ab_cnt", 16'(171 - i), 0, (i < 171), (i == 171));
        end
        step();
        chk_all("ab_hold", 16'h0, 0, 0, 1);
        ack_i = 1;
        step();
        ack_i = 0;
        chk_all("ab_ack", 16'h0, 1, 0, 0);
        step();
        chk_all("idle_hold", 16'h0, 1, 0, 0);

        // Load and Ack ignored in COUNT
        load_i = 1; a_i = 16'h0010; en_i = 1;
        step();
        a_i = 16'h1234; ack_i = 1;
        step();
        chk_all("cnt_ign1", 16'h000F, 0, 1, 0);
        step();
        chk_all("cnt_ign2", 16'h000E, 0, 1, 0);
        load_i = 0; ack_i = 0; en_i = 0;
        step();
        chk_all("cnt_pause", 16'h000E, 0, 1, 0);

        // Asynchronous abort mid-count
        rst_ni = 1'b0;
        #1;
        chk_all("abort", 16'h0, 1, 0, 0);
        #2;
        rst_ni = 1'b1;
        en_i = 1;
        step();
        chk_all("post_abort1", 16'h0, 1, 0, 0);
        step();
        chk_all("post_abort2", 16'h0, 1, 0, 0);

        // First load after release, with pattern-gated enable
        load_i = 1; a_i = 16'h0005; en_i = 0;
        step();
        load_i = 0;
        chk_all("pat_load", 16'h0005, 0, 1, 0);
        en_pat = 8'b1101_1001;  // bit0 first: 1,0,0,1,1,0,1,1
        exp_seq = '{16'd5, 16'd4, 16'd4, 16'd4, 16'd3, 16'd2, 16'd2, 16'd1, 16'd0};
        for (int i = 0; i < 8; i++) begin
            en_i = en_pat[i];
            step();
            chk_all("pat", exp_seq[i+1], 0, (i < 7), (i == 7));
        end
        en_i = 0; ack_i = 1;
        step();
        ack_i = 0;
        chk_all("pat_ack", 16'h0, 1, 0, 0);

        // Zero load goes straight to DONE; Ack+Load together only acks
        load_i = 1; a_i = 16'h0000;
        step();
        load_i = 0;
        chk_all("zero_load", 16'h0, 0, 0, 1);
        load_i = 1; a_i = 16'h0003; ack_i = 1;
        step();
        load_i = 0; ack_i = 0;
        chk_all("ack_load", 16'h0, 1, 0, 0);
        step();
        chk_all("ack_load_idle", 16'h0, 1, 0, 0);

        // Full range count
        load_i = 1; a_i = 16'hFFFF; en_i = 1;
        step();
        load_i = 0;
        chk_all("full_load", 16'hFFFF, 0, 1, 0);
        for (int i = 1; i <= 65535; i++) begin
            step();
            chk({"full.out"}, {16'h0, out_o}, 32'(65535 - i));
            chk({"full.done"}, {31'h0, done_o}, {31'h0, (i == 65535)});
        end
        step();
        chk_all("full_nowrap", 16'h0, 0, 0, 1);
        ack_i = 1;
        step();
        ack_i = 0;
        chk_all("full_ack", 16'h0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
